rspi_mem_ctrl: RTL
==================

Name: rspi_mem_ctrl

Overview:
- Parametrised SPI memory master that replaces the fixed two-device flash/RAM SPI port with NUM_CS chip selects.
- Adds a configurable SCK divider, configurable address width, 1–4 byte burst reads and writes, and a CS deselect hold time.
- Sits between the CPU bus/SoC fabric and the rspi_* pins.
- Issues standard READ (0x03) and WRITE (0x02) commands in SPI mode 0.

Parameters:
- NUM_CS, 2, number of attached SPI devices (1–8).
- ADDR_BITS, 24, address bits shifted after the command byte (8–32, multiple of 8).
- CLK_DIV, 1, clk cycles per SCK half-period (≥1).
- CS_HOLD, 2, idle clk cycles with all ce_n high after a transaction before req_ready rises (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = WRITE 0x02, 0 = READ 0x03.
- req_cs  in  CSW = max(1, clog2(NUM_CS))  target device index.
- req_addr  in  ADDR_BITS  byte address.
- req_len  in  2  byte count minus 1 (0..3 → 1..4 bytes).
- req_wdata  in  32  write data; byte k = bits [8k+7:8k].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  read data; byte k = bits [8k+7:8k]; unreceived bytes = 0.
- rspi_clk  out  1  SCK.
- rspi_mosi  out  1  serial data out.
- rspi_miso  in  1  serial data in.
- rspi_ce_n  out  NUM_CS  active-low chip selects.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, rspi_clk=0, rspi_mosi=0, rspi_ce_n all 1; FSM goes to IDLE. Reset asserted mid-transaction aborts in the next cycle to these values; no resp_valid is produced.
- FSM states: IDLE → SHIFT → DONE → HOLD → IDLE.
- IDLE:
  - req_ready=1.
  - When req_valid & req_ready at cycle T0: latch all request fields and form the bit count N = 8 + ADDR_BITS + 8·(req_len+1). Go to SHIFT.
- SHIFT:
  - From T1: ce_n[req_cs] = 0, req_ready = 0.
  - Each bit occupies 2·CLK_DIV cycles: SCK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MOSI updates only while SCK is low, at the start of each bit.
  - MISO is sampled on the clk edge where SCK rises 0→1.
  - Bit order: command MSB-first, then address MSB-first, then data bytes in order k=0..len, each byte MSB-first.
  - On reads, MOSI = 0 during data bits. MISO is sampled only during data bits, and byte k is assembled into resp_rdata[8k+7:8k].
  - On writes, MISO is ignored and resp_rdata = 0.
- DONE:
  - Entered at T1 + 2·CLK_DIV·N.
  - That cycle: SCK = 0, all ce_n = 1, resp_valid = 1 for exactly one cycle, resp_rdata valid. resp_rdata then holds until the next completion.
- HOLD:
  - All ce_n stay 1 for CS_HOLD cycles, counted from the DONE cycle inclusive.
  - req_ready = 1 at T1 + 2·CLK_DIV·N + CS_HOLD.
- req_cs ≥ NUM_CS: the request is accepted and timed identically, but no ce_n asserts; the read result is 0.
- Request fields are ignored while req_ready = 0. There is no queuing: a req_valid held high during a transaction is accepted only once req_ready returns.
- Counters: bit counter sized for N ≤ 8+32+32 = 72; divider counter wraps at CLK_DIV−1. No SCK glitch occurs at state boundaries.

Test Plan:
- **Single-byte read:** CLK_DIV=1, ADDR_BITS=24, read cs=0, addr=0x000010, len=0, slave model returns 0xA5.
  - MOSI carries 0x03, 0x00, 0x00, 0x10.
  - ce_n=2'b10 for exactly 80 cycles.
  - resp_valid at T1+80, resp_rdata=0x000000A5.
  - req_ready returns at T1+82.
- **4-byte read:** cs=1, addr=0x123456, len=3, slave returns 0x11, 0x22, 0x33, 0x44.
  - resp_rdata=0x44332211.
  - ce_n=2'b01 low for 2·(32+32)=128 cycles.
- **2-byte write:** CLK_DIV=3, write cs=0, addr=0x0000FF, wdata=0xBEEF, len=1.
  - MOSI carries 0x02, 0x00, 0x00, 0xFF, 0xEF, 0xBE.
  - Each SCK half-period is 3 clk cycles.
  - resp_rdata=0.
- **Mid-transaction reset:** assert rst at the 20th SHIFT cycle of a read.
  - Next cycle: all ce_n=1, rspi_clk=0, req_ready=1.
  - No resp_valid occurs.
- **Back-to-back requests:** req_valid held high with two queued reads.
  - The second is accepted exactly CS_HOLD cycles after the first resp_valid.
  - ce_n is high for ≥ CS_HOLD cycles between the two transactions.
- **Out-of-range CS:** NUM_CS=3, req_cs=3, read.
  - No ce_n falls; SCK still toggles 80 cycles.
  - resp_valid is issued with resp_rdata=0.

Source files
------------

// File: rtl/rspi_mem_ctrl.sv
// rtl/rspi_mem_ctrl.sv - parametrised SPI mode-0 memory master with NUM_CS chip selects
module rspi_mem_ctrl #(
    parameter int NUM_CS    = 2,
    parameter int ADDR_BITS = 24,
    parameter int CLK_DIV   = 1,
    parameter int CS_HOLD   = 2,
    localparam int CSW      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [CSW-1:0]       req_cs,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [1:0]           req_len,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 rspi_clk,
    output logic                 rspi_mosi,
    input  logic                 rspi_miso,
    output logic [NUM_CS-1:0]    rspi_ce_n
);

    // Header = command byte + address; data bits follow it in the frame
    localparam int HDR = 8 + ADDR_BITS;
    localparam int TXW = HDR + 32;
    localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW  = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;

    localparam logic [DW-1:0]  DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(CS_HOLD - 1);
    localparam logic [CSW-1:0] CS_MAX    = CSW'(NUM_CS - 1);
    localparam logic [6:0]     HDR_W     = 7'(HDR);
    localparam logic [4:0]     HDR_LO    = 5'(HDR % 32);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, HOLD} state_t;

    state_t           state_q, state_d;
    logic             wr_q;
    logic [CSW-1:0]   cs_q;
    logic [6:0]       last_bit_q;
    logic [6:0]       bit_cnt_q;
    logic [DW-1:0]    div_q;
    logic             sck_q;
    logic [TXW-1:0]   tx_q;
    logic [31:0]      rx_q;
    logic [31:0]      rdata_q;
    logic [HW-1:0]    hold_q;

    logic             div_end;
    logic             last_bit;
    logic             cs_ok;
    logic             in_data;
    logic [4:0]       d_off;
    logic [4:0]       rx_idx;

    assign div_end  = (div_q == DIV_LAST);
    assign last_bit = (bit_cnt_q == last_bit_q);
    assign cs_ok    = (cs_q <= CS_MAX);
    assign in_data  = (bit_cnt_q >= HDR_W);
    // Data bit offset modulo 32; byte k lands MSB-first in bits [8k+7:8k]
    assign d_off    = bit_cnt_q[4:0] - HDR_LO;
    assign rx_idx   = {d_off[4:3], ~d_off[2:0]};

    assign rspi_clk   = sck_q;
    assign resp_rdata = rdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state outputs; chip select only for in-range targets
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        rspi_mosi  = 1'b0;
        rspi_ce_n  = '1;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                rspi_mosi = tx_q[TXW-1];
                for (int i = 0; i < NUM_CS; i++) begin
                    if (cs_q == CSW'(i)) begin
                        rspi_ce_n[i] = 1'b0;
                    end
                end
                if (sck_q && div_end && last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                state_d    = (CS_HOLD > 1) ? HOLD : IDLE;
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, SCK divider, shift registers and deselect hold counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= 1'b0;
            cs_q       <= '0;
            last_bit_q <= '0;
            bit_cnt_q  <= '0;
            div_q      <= '0;
            sck_q      <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            rdata_q    <= '0;
            hold_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        wr_q       <= req_write;
                        cs_q       <= req_cs;
                        last_bit_q <= HDR_W + {2'b00, req_len, 3'b111};
                        bit_cnt_q  <= '0;
                        div_q      <= '0;
                        sck_q      <= 1'b0;
                        rx_q       <= '0;
                        tx_q       <= {(req_write ? 8'h02 : 8'h03), req_addr,
                                       (req_write ? {req_wdata[7:0], req_wdata[15:8],
                                                     req_wdata[23:16], req_wdata[31:24]}
                                                  : 32'h0)};
                    end
                end
                SHIFT: begin
                    if (div_end) begin
                        div_q <= '0;
                        sck_q <= ~sck_q;
                        if (!sck_q) begin
                            if (!wr_q && cs_ok && in_data) begin
                                rx_q[rx_idx] <= rspi_miso;
                            end
                        end else begin
                            tx_q      <= tx_q << 1;
                            bit_cnt_q <= bit_cnt_q + 7'd1;
                            if (last_bit) begin
                                rdata_q <= rx_q;
                            end
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                DONE: begin
                    hold_q <= HW'(1);
                end
                HOLD: begin
                    hold_q <= hold_q + HW'(1);
                end
                default: begin
                    hold_q <= '0;
                end
            endcase
        end
    end

endmodule
